// File: rtl/iir_coef_ctrl_pkg.sv
// Shared types and constants for the biquad coefficient controller.
// Q2.13 coefficients, default bank is a 1 MHz notch with r = 0.95.
package iir_ctrl_pkg;

    localparam int COEF_W  = 16;
    localparam int Q13_ONE = 8192;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t DEF_B0 = coef_t'(8192);
    localparam coef_t DEF_B1 = coef_t'(-16182);
    localparam coef_t DEF_B2 = coef_t'(8192);
    localparam coef_t DEF_A1 = coef_t'(-15373);
    localparam coef_t DEF_A2 = coef_t'(7393);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ARMED  = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    localparam logic [2:0] ADDR_B0 = 3'd0;
    localparam logic [2:0] ADDR_B1 = 3'd1;
    localparam logic [2:0] ADDR_B2 = 3'd2;
    localparam logic [2:0] ADDR_A1 = 3'd3;
    localparam logic [2:0] ADDR_A2 = 3'd4;

    typedef struct packed {
        coef_t b0;
        coef_t b1;
        coef_t b2;
        coef_t a1;
        coef_t a2;
    } coef_bank_t;

    localparam coef_bank_t DEF_BANK = '{
        b0: DEF_B0,
        b1: DEF_B1,
        b2: DEF_B2,
        a1: DEF_A1,
        a2: DEF_A2
    };

endpackage

// File: rtl/iir_coef_ctrl_if.sv
// Coefficient write port: valid/ready beat carrying addr, data and commit.
// master drives beats, slave (the controller) returns ready.
interface iir_coef_ctrl_if;
    import iir_ctrl_pkg::*;

    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_addr;
    coef_t      cfg_data;
    logic       cfg_commit;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        output cfg_commit,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_commit,
        output cfg_ready
    );

endinterface

// File: rtl/iir_coef_ctrl_stab_check.sv
// Combinational biquad denominator stability test (stability triangle).
// Widened by two bits so abs() of the most negative value and 1 + a2 cannot overflow.
module iir_stab_check
    import iir_ctrl_pkg::*;
(
    input  coef_t a1,
    input  coef_t a2,
    output logic  pass
);

    localparam int XW = COEF_W + 2;
    localparam logic signed [XW-1:0] ONE_X = XW'(Q13_ONE);

    logic signed [XW-1:0] a1_x;
    logic signed [XW-1:0] a2_x;
    logic signed [XW-1:0] a1_abs;
    logic signed [XW-1:0] a2_abs;
    logic signed [XW-1:0] a1_lim;

    assign a1_x   = {{2{a1[COEF_W-1]}}, a1};
    assign a2_x   = {{2{a2[COEF_W-1]}}, a2};
    assign a1_abs = a1_x[XW-1] ? -a1_x : a1_x;
    assign a2_abs = a2_x[XW-1] ? -a2_x : a2_x;
    assign a1_lim = ONE_X + a2_x;

    assign pass = (a2_abs < ONE_X) && (a1_abs < a1_lim);

endmodule

// File: rtl/iir_coef_ctrl.sv
// Run-time coefficient controller: shadow bank, stability check, sample-aligned swap.
// Optional IIR_COMMIT_CNT_EN adds a saturating commit_cnt output.
module iir_coef_ctrl
    import iir_ctrl_pkg::*;
#(
    parameter int SETTLE_SAMPLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    iir_coef_ctrl_if.slave       cfg,
    output coef_t                coef_b0,
    output coef_t                coef_b1,
    output coef_t                coef_b2,
    output coef_t                coef_a1,
    output coef_t                coef_a2,
    output logic                 filt_clr,
    output logic                 out_mask,
    output logic                 busy,
    output logic [1:0]           err_status,
    input  logic                 err_clr
`ifdef IIR_COMMIT_CNT_EN
    ,
    output logic [15:0]          commit_cnt
`endif
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] CHECK  = ST_CHECK;
    localparam logic [1:0] ARMED  = ST_ARMED;
    localparam logic [1:0] SETTLE = ST_SETTLE;

    localparam int CNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

    logic [1:0]       state;
    coef_bank_t       active;
    coef_bank_t       shadow;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       err_nxt;
    logic             accept;
    logic             illegal;
    logic             stab_ok;

    iir_stab_check u_stab (
        .a1   (shadow.a1),
        .a2   (shadow.a2),
        .pass (stab_ok)
    );

    assign cfg.cfg_ready = (state == IDLE);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign illegal       = cfg.cfg_addr > ADDR_A2;
    assign busy          = (state != IDLE);
    // Mask tracks SETTLE exactly: rises the cycle after the swap, falls after the last tick.
    assign out_mask      = (state == SETTLE);

    assign coef_b0 = active.b0;
    assign coef_b1 = active.b1;
    assign coef_b2 = active.b2;
    assign coef_a1 = active.a1;
    assign coef_a2 = active.a2;

    always_comb begin
        err_nxt = err_clr ? 2'b00 : err_status;
        if (accept && illegal) err_nxt[0] = 1'b1;
        if (state == CHECK && !stab_ok) err_nxt[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            active     <= DEF_BANK;
            shadow     <= DEF_BANK;
            cnt        <= '0;
            filt_clr   <= 1'b0;
            err_status <= 2'b00;
`ifdef IIR_COMMIT_CNT_EN
            commit_cnt <= '0;
`endif
        end else begin
            filt_clr   <= 1'b0;
            err_status <= err_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cfg.cfg_addr)
                            ADDR_B0: shadow.b0 <= cfg.cfg_data;
                            ADDR_B1: shadow.b1 <= cfg.cfg_data;
                            ADDR_B2: shadow.b2 <= cfg.cfg_data;
                            ADDR_A1: shadow.a1 <= cfg.cfg_data;
                            ADDR_A2: shadow.a2 <= cfg.cfg_data;
                            default: ;
                        endcase
                        if (cfg.cfg_commit) state <= CHECK;
                    end
                end
                CHECK: begin
                    if (stab_ok) begin
                        state <= ARMED;
                    end else begin
                        shadow <= active;
                        state  <= IDLE;
                    end
                end
                ARMED: begin
                    if (sample_en) begin
                        active   <= shadow;
                        filt_clr <= 1'b1;
                        cnt      <= CNT_W'(SETTLE_SAMPLES);
                        state    <= (SETTLE_SAMPLES == 0) ? IDLE : SETTLE;
`ifdef IIR_COMMIT_CNT_EN
                        if (commit_cnt != 16'hFFFF) commit_cnt <= commit_cnt + 16'd1;
`endif
                    end
                end
                SETTLE: begin
                    if (sample_en) begin
                        cnt <= cnt - 1'b1;
                        if (cnt <= CNT_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Scoreboard bench for iir_coef_ctrl: expected banks queued at commit, compared at filt_clr.
// SETTLE_SAMPLES = 4; sample_en every 40 cycles when the generator is running.
module tb_iir_coef_ctrl;
    import iir_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gen_se = 1'b0;
    logic        man_se = 1'b0;
    logic        sample_en;
    logic        err_clr = 1'b0;
    logic        samp_run = 1'b0;
    coef_t       coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
    logic        filt_clr, out_mask, busy;
    logic [1:0]  err_status;
`ifdef IIR_COMMIT_CNT_EN
    logic [15:0] commit_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int se_cnt   = 0;
    logic se_q   = 1'b0;
    coef_bank_t sb[$];

    iir_coef_ctrl_if cfg ();

    assign sample_en = gen_se | man_se;

    iir_coef_ctrl #(.SETTLE_SAMPLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .cfg        (cfg),
        .coef_b0    (coef_b0),
        .coef_b1    (coef_b1),
        .coef_b2    (coef_b2),
        .coef_a1    (coef_a1),
        .coef_a2    (coef_a2),
        .filt_clr   (filt_clr),
        .out_mask   (out_mask),
        .busy       (busy),
        .err_status (err_status),
        .err_clr    (err_clr)
`ifdef IIR_COMMIT_CNT_EN
        ,
        .commit_cnt (commit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic coef_bank_t mk(input int b0, b1, b2, a1, a2);
        coef_bank_t b;
        b.b0 = coef_t'(b0);
        b.b1 = coef_t'(b1);
        b.b2 = coef_t'(b2);
        b.a1 = coef_t'(a1);
        b.a2 = coef_t'(a2);
        return b;
    endfunction

    function automatic coef_bank_t cur_bank();
        return mk(coef_b0, coef_b1, coef_b2, coef_a1, coef_a2);
    endfunction

    task automatic check_bank(input string tag, input coef_bank_t e);
        check({tag, "_b0"}, coef_b0, e.b0);
        check({tag, "_b1"}, coef_b1, e.b1);
        check({tag, "_b2"}, coef_b2, e.b2);
        check({tag, "_a1"}, coef_a1, e.a1);
        check({tag, "_a2"}, coef_a2, e.a2);
    endtask

    task automatic send(input logic [2:0] addr, input int data, input logic commit);
        int n;
        n = 0;
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_addr   = addr;
        cfg.cfg_data   = coef_t'(data);
        cfg.cfg_commit = commit;
        while (!cfg.cfg_ready && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("send_timeout", n, 0);
        tick();
        cfg.cfg_valid  = 1'b0;
        cfg.cfg_commit = 1'b0;
    endtask

    task automatic wait_swap(input coef_bank_t prev);
        int n;
        int early;
        int se0;
        int masked;
        n = 0;
        early = 0;
        while (!filt_clr && n < 400) begin
            if (cur_bank() != prev) early++;
            tick();
            n++;
        end
        check("swap_seen", filt_clr, 1);
        check("pre_swap_hold", early, 0);
        check("mask_on", out_mask, 1);
        se0 = se_cnt;
        tick();
        check("clr_one_cycle", filt_clr, 0);
        n = 0;
        masked = 0;
        while (busy && n < 1000) begin
            if (!out_mask) masked++;
            tick();
            n++;
        end
        check("settle_ticks", se_cnt - se0, 4);
        check("mask_hold", masked, 0);
        check("mask_off", out_mask, 0);
        check("idle_ready", cfg.cfg_ready, 1);
    endtask

    always @(posedge clk) begin
        se_q = sample_en;
        if (!rst && sample_en) se_cnt++;
    end

    always @(negedge clk) begin
        coef_bank_t e;
        if (!rst && filt_clr) begin
            check("clr_after_tick", se_q, 1);
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_bank("swap", e);
            end
        end
    end

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (samp_run) begin
                c++;
                gen_se = (c % 40 == 0);
            end else begin
                c = 0;
                gen_se = 1'b0;
            end
        end
    end

    initial begin
        coef_bank_t b_def, b1, b3, b4, b5;
        int n;
        int bad;
        b_def = mk(8192, -16182, 8192, -15373, 7393);
        b1    = mk(8192, -15000, 8192, -14000, 6000);
        b3    = mk(4096, -15000, 8192, -14000, 6000);
        b4    = mk(1000, -15000, 8192, -14000, 6000);
        b5    = mk(1000, -15000, 8000, -14000, 6000);
        cfg.cfg_valid  = 1'b0;
        cfg.cfg_addr   = 3'd0;
        cfg.cfg_data   = '0;
        cfg.cfg_commit = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        check_bank("rst", b_def);
        check("rst_ready", cfg.cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err_status, 0);
        check("rst_mask", out_mask, 0);
        check("rst_clr", filt_clr, 0);

        // normal update; sample_en on the commit beat and in CHECK must not swap
        send(3'd1, -15000, 1'b0);
        send(3'd3, -14000, 1'b0);
        man_se = 1'b1;
        send(3'd4, 6000, 1'b1);
        sb.push_back(b1);
        check("check_busy", busy, 1);
        tick();
        man_se = 1'b0;
        check("armed_busy", busy, 1);
        check("armed_ready", cfg.cfg_ready, 0);
        check("armed_noclr", filt_clr, 0);
        check_bank("armed_hold", b_def);
        repeat (3) tick();
        samp_run = 1'b1;
        wait_swap(b_def);
        samp_run = 1'b0;
        check_bank("upd", b1);

        // unstable commit rejected, shadow reloaded
        send(3'd4, 8192, 1'b1);
        tick();
        check("unst_ready", cfg.cfg_ready, 1);
        check("unst_busy", busy, 0);
        check("unst_err", err_status, 2);
        check_bank("unst", b1);
        send(3'd0, 8192, 1'b1);
        sb.push_back(b1);
        samp_run = 1'b1;
        wait_swap(b1);
        samp_run = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("errclr1", err_status, 0);

        // illegal addresses
        send(3'd6, 1234, 1'b0);
        check("ill_err", err_status, 1);
        err_clr = 1'b1;
        send(3'd7, 55, 1'b0);
        err_clr = 1'b0;
        check("ill_setwins", err_status, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ill_clr", err_status, 0);
        send(3'd5, 1234, 1'b1);
        sb.push_back(b1);
        check("ill_commit_err", err_status, 1);
        samp_run = 1'b1;
        wait_swap(b1);
        samp_run = 1'b0;

        // backpressure while ARMED/SETTLE
        send(3'd0, 4096, 1'b1);
        sb.push_back(b3);
        tick();
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_addr   = 3'd0;
        cfg.cfg_data   = coef_t'(1000);
        cfg.cfg_commit = 1'b0;
        samp_run = 1'b1;
        n = 0;
        bad = 0;
        while (!cfg.cfg_ready && n < 1000) begin
            if (!busy) bad++;
            tick();
            n++;
        end
        check("bp_held", n > 100, 1);
        check("bp_ready", cfg.cfg_ready, 1);
        check("bp_bad", bad, 0);
        tick();
        cfg.cfg_valid = 1'b0;
        samp_run = 1'b0;
        check("bp_idle", busy, 0);
        check_bank("bp_active", b3);
        send(3'd1, -15000, 1'b1);
        sb.push_back(b4);
        samp_run = 1'b1;
        wait_swap(b3);
        samp_run = 1'b0;

        // reset during SETTLE
        send(3'd2, 8000, 1'b1);
        sb.push_back(b5);
        samp_run = 1'b1;
        n = 0;
        while (!filt_clr && n < 400) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("pre_rst_mask", out_mask, 1);
        check_bank("pre_rst", b5);
`ifdef IIR_COMMIT_CNT_EN
        check("cnt_pre", commit_cnt, 6);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        samp_run = 1'b0;
        check_bank("rst2", b_def);
        check("rst2_mask", out_mask, 0);
        check("rst2_clr", filt_clr, 0);
        check("rst2_busy", busy, 0);
        check("rst2_ready", cfg.cfg_ready, 1);
`ifdef IIR_COMMIT_CNT_EN
        check("rst2_cnt", commit_cnt, 0);
`endif
        repeat (5) tick();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
